hugoc_seq_game_core: RTL and testbench
======================================

Name: hugoc_seq_game_core

Overview:
Parametrised sequence-memory game core ("Simon"-style) for the HugoC Tiny Tapeout game project.
- Each round appends one pseudo-random symbol and replays the whole sequence on N_CH LEDs.
- The player then reproduces the sequence on N_CH buttons.
- Generalises the single-mode game to configurable channel count, sequence depth and timing, and adds timeout, win and lose handling.
- Sits between the tt_um_HugoC_game pin mapping (ui_in buttons, uo_out LEDs/score) and the top-level wrapper.

Parameters:
- N_CH, 4, number of buttons/LEDs; power of two, range 2..8; SYM_W = clog2(N_CH).
- MAX_LEN, 16, maximum sequence length; reaching it with a correct entry is a win.
- SHOW_CYC, 4096, cycles each LED stays lit during replay.
- GAP_CYC, 1024, dark cycles between replayed symbols.
- TIMEOUT_CYC, 65535, maximum cycles allowed between presses in INPUT.
- SEED, 16'hACE1, LFSR reset value; a value of 0 is replaced by 1.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- ena, input, 1, low freezes all state, counters and LFSR.
- start, input, 1, level; sampled in IDLE/WIN/LOSE to begin a new game.
- btn, input, N_CH, button levels, already synchronised upstream.
- led, output, N_CH, LED drive.
- score, output, 8, completed rounds, zero-extended.
- state_o, output, 3, current FSM state encoding.
- win, output, 1, high while in WIN.
- lose, output, 1, high while in LOSE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; led=0, score=0, win=0, lose=0, len=0, idx=0.
  - LFSR=SEED (0 replaced by 1); btn_prev=0; all counters 0.
- LFSR: 16-bit Fibonacci, shift left, feedback l[15]^l[13]^l[12]^l[10]; advances every cycle while ena=1 regardless of state.
- Sequence buffer: MAX_LEN x SYM_W registers. Symbol s is displayed and expected as one-hot (1<<s).
- Press event: btn!=0 while btn_prev==0. btn_prev is registered each cycle. Holding a button produces exactly one event; the next event requires all buttons released.
- States: IDLE=0, ADD=1, SHOW_ON=2, SHOW_GAP=3, INPUT=4, WIN=5, LOSE=6.
- IDLE/WIN/LOSE, start=1:
  - Next cycle: len=0, score=0, win=0, lose=0, state goes to ADD.
  - Otherwise the state holds.
- ADD (1 cycle):
  - buf[len] = LFSR[SYM_W-1:0]; len++; idx=0; state goes to SHOW_ON.
- SHOW_ON:
  - led=onehot(buf[idx]) for exactly SHOW_CYC cycles, then state goes to SHOW_GAP.
- SHOW_GAP:
  - led=0 for GAP_CYC cycles.
  - If idx<len-1: idx++ and return to SHOW_ON.
  - Else: idx=0, timeout counter=0, state goes to INPUT.
- INPUT:
  - led=btn (echo). Timeout counter increments each cycle and clears on every press event.
  - Press event equal to onehot(buf[idx]):
    - Correct and idx<len-1: idx++.
    - Correct and idx==len-1: score++. If len==MAX_LEN go to WIN, else go to ADD.
  - Press event not equal (including multi-hot): go to LOSE.
  - Counter reaches TIMEOUT_CYC with no event: go to LOSE.
  - A press event and a timeout in the same cycle: the press takes priority.
- WIN: led=all ones, win=1. Score is frozen.
- LOSE: led=onehot(buf[idx]) (the expected symbol), lose=1. Score is frozen.
- ena=0: every register holds; outputs keep their last values.
- Reset mid-operation: immediate return to the reset values; the sequence buffer contents become don't-care.
- score saturates at 255. It cannot exceed MAX_LEN in practice.

Decomposition:
- Package hugoc_game_pkg:
  - State encoding localparams (3-bit).
  - LFSR tap constant.
  - onehot(sym) function.
- Sub-module hugoc_lfsr16: ports clk, rst_n, ena, q[15:0]; parameter SEED.
- Everything else lives in hugoc_seq_game_core.

Test Plan:
(Bench parameters: N_CH=4, MAX_LEN=3, SHOW_CYC=4, GAP_CYC=2, TIMEOUT_CYC=20, SEED=16'hACE1. The bench keeps a reference LFSR model.)
- Reset: rst_n low mid-SHOW_ON → same cycle led=0, state_o=0, score=0; after release, state stays IDLE until start.
- Round 1 replay: start=1 for 1 cycle → ADD, then led=onehot(model sym0) for exactly 4 cycles, 2 dark cycles, then state_o=4.
- Correct play: press the correct button for each round, releasing between presses → score reaches 1, then 2, then 3; after the last press state_o=5, win=1, led=4'b1111.
- Wrong press: in round 2, idx=1, press a wrong one-hot value → next cycle state_o=6, lose=1, led=expected symbol, score=1.
- Held button and multi-hot: holding the correct button for 10 cycles counts once (idx increments by 1); btn=4'b0011 → LOSE.
- Timeout and ena: no press for 20 cycles in INPUT → LOSE. Repeat with ena=0 for 30 cycles in the middle → no timeout until 20 enabled cycles have elapsed.

Source files
------------

// File: rtl/hugoc_game_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hugoc_game_pkg
// Description : Shared FSM encodings, LFSR taps and one-hot helper for the
//               HugoC sequence-memory game.
// Revision    : 1.0 - initial release
// ============================================================================
package hugoc_game_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_ADD      = 3'd1;
    localparam logic [2:0] ST_SHOW_ON  = 3'd2;
    localparam logic [2:0] ST_SHOW_GAP = 3'd3;
    localparam logic [2:0] ST_INPUT    = 3'd4;
    localparam logic [2:0] ST_WIN      = 3'd5;
    localparam logic [2:0] ST_LOSE     = 3'd6;

    // Feedback taps at bits 15, 13, 12 and 10.
    localparam logic [15:0] C_LFSR_TAPS = 16'hB400;

    function automatic logic [7:0] onehot(input logic [2:0] sym);
        onehot = 8'd1 << sym;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hugoc_lfsr16.sv
`default_nettype none
// ============================================================================
// Module      : hugoc_lfsr16
// Description : 16-bit Fibonacci LFSR, shift-left, free-running while enabled.
// Revision    : 1.0 - initial release
// ============================================================================
module hugoc_lfsr16
    import hugoc_game_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ena,
    output logic [15:0] q
);

    // An all-zero state would lock the register up.
    localparam logic [15:0] RST_VAL = (SEED == 16'h0000) ? 16'h0001 : SEED;

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[14:0], ^(lfsr_q & C_LFSR_TAPS)};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= RST_VAL;
        end else if (ena) begin
            lfsr_q <= lfsr_d;
        end
    end

    assign q = lfsr_q;

endmodule
`default_nettype wire

// File: rtl/hugoc_seq_game_core.sv
`default_nettype none
// ============================================================================
// Module      : hugoc_seq_game_core
// Description : Simon-style sequence-memory game: grow, replay, check input.
// Revision    : 1.0 - initial release
// ============================================================================
module hugoc_seq_game_core
    import hugoc_game_pkg::*;
#(
    parameter int unsigned N_CH        = 4,
    parameter int unsigned MAX_LEN     = 16,
    parameter int unsigned SHOW_CYC    = 4096,
    parameter int unsigned GAP_CYC     = 1024,
    parameter int unsigned TIMEOUT_CYC = 65535,
    parameter logic [15:0] SEED        = 16'hACE1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ena,
    input  logic            start,
    input  logic [N_CH-1:0] btn,
    output logic [N_CH-1:0] led,
    output logic [7:0]      score,
    output logic [2:0]      state_o,
    output logic            win,
    output logic            lose
);

    localparam int unsigned SYM_W   = $clog2(N_CH);
    localparam int unsigned IDX_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1);
    localparam int unsigned CNT_A   = (SHOW_CYC > GAP_CYC) ? SHOW_CYC : GAP_CYC;
    localparam int unsigned CNT_MAX = (TIMEOUT_CYC > CNT_A) ? TIMEOUT_CYC : CNT_A;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    logic [2:0]       state_q, state_d;
    logic [LEN_W-1:0] len_q,   len_d;
    logic [IDX_W-1:0] idx_q,   idx_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [7:0]       score_q, score_d;
    logic [N_CH-1:0]  led_q,   led_d;
    logic [N_CH-1:0]  btn_prev_q;
    logic [SYM_W-1:0] seq_q [MAX_LEN];
    logic [SYM_W-1:0] seq_d [MAX_LEN];

    logic [15:0]       lfsr_q;
    logic [15-SYM_W:0] lfsr_unused;
    logic              w_press;
    logic              w_press_ok;
    logic              w_last;

    hugoc_lfsr16 #(
        .SEED (SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .q     (lfsr_q)
    );

    assign lfsr_unused = lfsr_q[15:SYM_W];

    assign w_press    = (btn != '0) && (btn_prev_q == '0);
    assign w_press_ok = (8'(btn) == onehot(3'(seq_q[idx_q])));
    assign w_last     = (LEN_W'(idx_q) == (len_q - LEN_W'(1)));

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        score_d = score_q;
        seq_d   = seq_q;

        case (state_q)
            ST_IDLE, ST_WIN, ST_LOSE: begin
                if (start) begin
                    state_d = ST_ADD;
                    len_d   = '0;
                    idx_d   = '0;
                    cnt_d   = '0;
                    score_d = '0;
                end
            end
            ST_ADD: begin
                seq_d[len_q[IDX_W-1:0]] = lfsr_q[SYM_W-1:0];
                len_d   = len_q + LEN_W'(1);
                idx_d   = '0;
                cnt_d   = '0;
                state_d = ST_SHOW_ON;
            end
            ST_SHOW_ON: begin
                if (cnt_q == CNT_W'(SHOW_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_SHOW_GAP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_SHOW_GAP: begin
                if (cnt_q == CNT_W'(GAP_CYC - 1)) begin
                    cnt_d = '0;
                    if (!w_last) begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = ST_SHOW_ON;
                    end else begin
                        idx_d   = '0;
                        state_d = ST_INPUT;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_INPUT: begin
                // A press in the timeout cycle still counts.
                if (w_press) begin
                    cnt_d = '0;
                    if (!w_press_ok) begin
                        state_d = ST_LOSE;
                    end else if (!w_last) begin
                        idx_d = idx_q + IDX_W'(1);
                    end else begin
                        score_d = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
                        state_d = (len_q == LEN_W'(MAX_LEN)) ? ST_WIN : ST_ADD;
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    state_d = ST_LOSE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // LED drive is registered from the next state so it lines up with state_o.
        case (state_d)
            ST_SHOW_ON: led_d = N_CH'(onehot(3'(seq_d[idx_d])));
            ST_INPUT:   led_d = btn;
            ST_WIN:     led_d = '1;
            ST_LOSE:    led_d = N_CH'(onehot(3'(seq_d[idx_d])));
            default:    led_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            idx_q      <= '0;
            cnt_q      <= '0;
            score_q    <= '0;
            led_q      <= '0;
            btn_prev_q <= '0;
        end else if (ena) begin
            state_q    <= state_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            score_q    <= score_d;
            led_q      <= led_d;
            btn_prev_q <= btn;
        end
    end

    // Sequence storage needs no reset; it is always written before being read.
    always_ff @(posedge clk) begin
        if (ena) begin
            seq_q <= seq_d;
        end
    end

    assign led     = led_q;
    assign score   = score_q;
    assign state_o = state_q;
    assign win     = (state_q == ST_WIN);
    assign lose    = (state_q == ST_LOSE);

endmodule
`default_nettype wire

// File: tb/tb_hugoc_seq_game_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_hugoc_seq_game_core
// Description : Self-checking bench for hugoc_seq_game_core with LFSR model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hugoc_seq_game_core;

    localparam int unsigned N_CH = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            ena;
    logic            start;
    logic [N_CH-1:0] btn;
    logic [N_CH-1:0] led;
    logic [7:0]      score;
    logic [2:0]      state_o;
    logic            win;
    logic            lose;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [2:0] st;
        logic [3:0] led;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] m_lfsr;
    logic [1:0]  seq [3];

    hugoc_seq_game_core #(
        .N_CH        (4),
        .MAX_LEN     (3),
        .SHOW_CYC    (4),
        .GAP_CYC     (2),
        .TIMEOUT_CYC (20),
        .SEED        (16'hACE1)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .start   (start),
        .btn     (btn),
        .led     (led),
        .score   (score),
        .state_o (state_o),
        .win     (win),
        .lose    (lose)
    );

    always #5 clk = ~clk;

    // Reference LFSR: Fibonacci, taps 15/13/12/10, frozen by ena.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_lfsr <= 16'hACE1;
        end else if (ena) begin
            m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        end
    end

    function automatic logic [3:0] oh(input logic [1:0] s);
        oh = 4'b0001 << s;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // From IDLE/WIN/LOSE: request a game and land in the ADD cycle.
    task automatic begin_game();
        start = 1'b1;
        cyc();
        start = 1'b0;
        seq[0] = m_lfsr[1:0];
    endtask

    // Scoreboard-driven replay check for a sequence of length n; ends on first INPUT cycle.
    task automatic test_replay(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            repeat (4) sb.push_back('{st: 3'd2, led: oh(seq[i])});
            repeat (2) sb.push_back('{st: 3'd3, led: 4'b0000});
        end
        sb.push_back('{st: 3'd4, led: 4'b0000});
        while (sb.size() > 0) begin
            cyc();
            e = sb.pop_front();
            checks++;
            if (state_o !== e.st || led !== e.led) begin
                errors++;
                $display("FAIL replay_n%0d: got state=%0d led=%b expected state=%0d led=%b",
                         n, state_o, led, e.st, e.led);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) cyc();
        checks++;
        if (state_o !== 3'd0 || led !== 4'b0 || score !== 8'd0 || win !== 1'b0 || lose !== 1'b0) begin
            errors++;
            $display("FAIL reset_vals: got state=%0d led=%b score=%0d win=%b lose=%b expected 0/0000/0/0/0",
                     state_o, led, score, win, lose);
        end
        rst_n = 1'b1;
        repeat (5) cyc();
        checks++;
        if (state_o !== 3'd0) begin
            errors++;
            $display("FAIL idle_hold: got state=%0d expected 0", state_o);
        end
    endtask

    task automatic test_round1();
        begin_game();
        checks++;
        if (state_o !== 3'd1) begin
            errors++;
            $display("FAIL add_state: got %0d expected 1", state_o);
        end
        test_replay(1);
    endtask

    task automatic test_correct_play();
        btn = oh(seq[0]);
        cyc();
        checks++;
        if (score !== 8'd1 || state_o !== 3'd1) begin
            errors++;
            $display("FAIL round1_done: got score=%0d state=%0d expected 1/1", score, state_o);
        end
        seq[1] = m_lfsr[1:0];
        btn = 4'b0;
        test_replay(2);
        btn = oh(seq[0]);
        cyc();
        checks++;
        if (state_o !== 3'd4 || score !== 8'd1 || led !== oh(seq[0])) begin
            errors++;
            $display("FAIL r2_first: got state=%0d score=%0d led=%b expected 4/1/%b",
                     state_o, score, led, oh(seq[0]));
        end
        btn = 4'b0;
        cyc();
        btn = oh(seq[1]);
        cyc();
        checks++;
        if (score !== 8'd2 || state_o !== 3'd1) begin
            errors++;
            $display("FAIL round2_done: got score=%0d state=%0d expected 2/1", score, state_o);
        end
        seq[2] = m_lfsr[1:0];
        btn = 4'b0;
        test_replay(3);
        for (int i = 0; i < 3; i++) begin
            btn = oh(seq[i]);
            cyc();
            btn = 4'b0;
            if (i < 2) cyc();
        end
        checks++;
        if (state_o !== 3'd5 || win !== 1'b1 || led !== 4'b1111 || score !== 8'd3) begin
            errors++;
            $display("FAIL win: got state=%0d win=%b led=%b score=%0d expected 5/1/1111/3",
                     state_o, win, led, score);
        end
        repeat (3) cyc();
        checks++;
        if (state_o !== 3'd5 || score !== 8'd3) begin
            errors++;
            $display("FAIL win_hold: got state=%0d score=%0d expected 5/3", state_o, score);
        end
    endtask

    task automatic test_wrong_press();
        logic [1:0] bad;
        begin_game();
        checks++;
        if (score !== 8'd0 || win !== 1'b0) begin
            errors++;
            $display("FAIL restart_clear: got score=%0d win=%b expected 0/0", score, win);
        end
        test_replay(1);
        btn = oh(seq[0]);
        cyc();
        seq[1] = m_lfsr[1:0];
        btn = 4'b0;
        test_replay(2);
        btn = oh(seq[0]);
        cyc();
        btn = 4'b0;
        cyc();
        bad = seq[1] + 2'd1;
        btn = oh(bad);
        cyc();
        btn = 4'b0;
        checks++;
        if (state_o !== 3'd6 || lose !== 1'b1 || led !== oh(seq[1]) || score !== 8'd1) begin
            errors++;
            $display("FAIL wrong_press: got state=%0d lose=%b led=%b score=%0d expected 6/1/%b/1",
                     state_o, lose, led, score, oh(seq[1]));
        end
    endtask

    task automatic test_held_multihot();
        begin_game();
        test_replay(1);
        btn = oh(seq[0]);
        cyc();
        seq[1] = m_lfsr[1:0];
        btn = 4'b0;
        test_replay(2);
        btn = oh(seq[0]);
        repeat (10) cyc();
        checks++;
        if (state_o !== 3'd4 || led !== oh(seq[0])) begin
            errors++;
            $display("FAIL held_once: got state=%0d led=%b expected 4/%b", state_o, led, oh(seq[0]));
        end
        btn = 4'b0;
        cyc();
        btn = 4'b0011;
        cyc();
        btn = 4'b0;
        checks++;
        if (state_o !== 3'd6 || led !== oh(seq[1])) begin
            errors++;
            $display("FAIL multihot: got state=%0d led=%b expected 6/%b", state_o, led, oh(seq[1]));
        end
    endtask

    task automatic test_timeout();
        begin_game();
        test_replay(1);
        repeat (19) cyc();
        checks++;
        if (state_o !== 3'd4) begin
            errors++;
            $display("FAIL timeout_early: got state=%0d expected 4", state_o);
        end
        cyc();
        checks++;
        if (state_o !== 3'd6 || lose !== 1'b1 || led !== oh(seq[0])) begin
            errors++;
            $display("FAIL timeout: got state=%0d lose=%b led=%b expected 6/1/%b",
                     state_o, lose, led, oh(seq[0]));
        end
        begin_game();
        test_replay(1);
        repeat (10) cyc();
        ena = 1'b0;
        repeat (30) cyc();
        checks++;
        if (state_o !== 3'd4 || lose !== 1'b0) begin
            errors++;
            $display("FAIL ena_freeze: got state=%0d lose=%b expected 4/0", state_o, lose);
        end
        ena = 1'b1;
        repeat (9) cyc();
        checks++;
        if (state_o !== 3'd4) begin
            errors++;
            $display("FAIL ena_resume: got state=%0d expected 4", state_o);
        end
        cyc();
        checks++;
        if (state_o !== 3'd6) begin
            errors++;
            $display("FAIL ena_timeout: got state=%0d expected 6", state_o);
        end
    endtask

    task automatic test_reset_mid();
        begin_game();
        test_replay(1);
        btn = oh(seq[0]);
        cyc();
        btn = 4'b0;
        cyc();
        cyc();
        checks++;
        if (state_o !== 3'd2 || score !== 8'd1) begin
            errors++;
            $display("FAIL pre_reset: got state=%0d score=%0d expected 2/1", state_o, score);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (state_o !== 3'd0 || led !== 4'b0 || score !== 8'd0 || win !== 1'b0 || lose !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got state=%0d led=%b score=%0d expected 0/0000/0",
                     state_o, led, score);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) cyc();
        checks++;
        if (state_o !== 3'd0) begin
            errors++;
            $display("FAIL post_reset_idle: got state=%0d expected 0", state_o);
        end
        begin_game();
        checks++;
        if (state_o !== 3'd1) begin
            errors++;
            $display("FAIL post_reset_add: got state=%0d expected 1", state_o);
        end
        test_replay(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        ena   = 1'b1;
        start = 1'b0;
        btn   = 4'b0;
        test_reset();
        test_round1();
        test_correct_play();
        test_wrong_press();
        test_held_multihot();
        test_timeout();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
